gigatron_video_out: RTL

- Parametrised video output stage for the Gigatron core.
- Generates the pixel clock-enable from clk_sys and samples the raw 8-bit Gigatron output port on that enable.
- Expands N-bit colour to the output width by bit replication and applies configurable sync polarity.
- Derives hblank/vblank by counting pixels and lines from sync edges; feeds the MiSTer video path and the Verilator SDL bench.

---
 rtl/gigatron_video_pkg.sv | 25 ++
 rtl/gigatron_video_if.sv | 14 +
 rtl/gigatron_ce_div.sv | 21 ++
 rtl/gigatron_video_out.sv | 97 +++++++++
 4 files changed

// File: rtl/gigatron_video_pkg.sv
// gigatron_video_pkg: output-port layout, colour expansion and counter sizing for the video stage
package gigatron_video_pkg;
  localparam int R_LSB = 0;
  localparam int G_LSB = 2;
  localparam int B_LSB = 4;
  localparam int HS_N  = 6;
  localparam int VS_N  = 7;
  typedef struct packed {
    logic       vs_n;
    logic       hs_n;
    logic [1:0] b;
    logic [1:0] g;
    logic [1:0] r;
  } port_t;
  function automatic int cnt_width(input int h_total, input int v_total);
    return $clog2(h_total > v_total ? h_total : v_total) + 1;
  endfunction
  function automatic logic [31:0] expand(input logic [31:0] v, input int ib, input int ob);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < ob) r[5'(ob - 1 - i)] = v[5'(ib - 1 - (i % ib))];
    return r;
  endfunction
endpackage

// File: rtl/gigatron_video_if.sv
// gigatron_video_if: pixel-rate video bundle towards the MiSTer / SDL sinks
interface gigatron_video_if #(parameter int OUT_BPC = 8);
  logic               ce_pix;
  logic [OUT_BPC-1:0] vga_r;
  logic [OUT_BPC-1:0] vga_g;
  logic [OUT_BPC-1:0] vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               hblank;
  logic               vblank;
  logic               frame_start;
  modport master(output ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, hblank, vblank, frame_start);
  modport slave(input ce_pix, vga_r, vga_g, vga_b, vga_hs, vga_vs, hblank, vblank, frame_start);
endinterface

// File: rtl/gigatron_ce_div.sv
// gigatron_ce_div: divides clk_sys into a one-cycle enable; tick is the cycle before ce goes high
module gigatron_ce_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic ce
);
  logic [7:0] cnt;
  assign tick = run && cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk_sys)
    if (reset) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else begin
      ce <= tick;
      if (run) cnt <= tick ? '0 : cnt + 8'd1;
    end
endmodule

// File: rtl/gigatron_video_out.sv
// gigatron_video_out: samples the Gigatron output port per pixel, expands colour, derives blanking.
// Optional scanline dimming with GIGATRON_VIDEO_SCANLINE_EN.
module gigatron_video_out
  import gigatron_video_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int IN_BPC   = 2,
  parameter int OUT_BPC  = 8,
  parameter int H_BP     = 12,
  parameter int H_ACT    = 160,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int SYNC_POS = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       port_in,
  input  logic             scanline_on,
  gigatron_video_if.master vid
);
  localparam int CW = cnt_width(H_BP + H_ACT, V_BP + V_ACT);
  localparam logic [CW-1:0] SAT = {CW{1'b1}};
  localparam logic SYNC_IDLE = SYNC_POS == 0;
  logic               tick;
  port_t              p1;
  logic               prev_hs, prev_vs;
  logic               hs_rise, hs_fall, vs_rise;
  logic [CW-1:0]      hcnt, vcnt, h_nxt, v_nxt;
  logic               act_h, act_v;
  logic [OUT_BPC-1:0] r_e, g_e, b_e, r_x, g_x, b_x;
  gigatron_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_sys(clk_sys),
    .reset  (reset),
    .run    (run),
    .tick   (tick),
    .ce     (vid.ce_pix)
  );
  always_comb begin
    hs_rise = p1.hs_n & ~prev_hs;
    hs_fall = ~p1.hs_n & prev_hs;
    vs_rise = p1.vs_n & ~prev_vs;
    h_nxt   = hs_rise ? '0 : hcnt == SAT ? SAT : hcnt + 1'b1;
    v_nxt   = vs_rise ? '0 : (hs_fall && vcnt != SAT) ? vcnt + 1'b1 : vcnt;
    act_h   = h_nxt >= CW'(H_BP) && h_nxt < CW'(H_BP + H_ACT);
    act_v   = v_nxt >= CW'(V_BP) && v_nxt < CW'(V_BP + V_ACT);
    r_e     = OUT_BPC'(expand(32'(p1[R_LSB +: IN_BPC]), IN_BPC, OUT_BPC));
    g_e     = OUT_BPC'(expand(32'(p1[G_LSB +: IN_BPC]), IN_BPC, OUT_BPC));
    b_e     = OUT_BPC'(expand(32'(p1[B_LSB +: IN_BPC]), IN_BPC, OUT_BPC));
`ifdef GIGATRON_VIDEO_SCANLINE_EN
    r_x     = (scanline_on && v_nxt[0]) ? r_e >> 1 : r_e;
    g_x     = (scanline_on && v_nxt[0]) ? g_e >> 1 : g_e;
    b_x     = (scanline_on && v_nxt[0]) ? b_e >> 1 : b_e;
`else
    r_x     = r_e;
    g_x     = g_e;
    b_x     = b_e;
`endif
  end
`ifndef GIGATRON_VIDEO_SCANLINE_EN
  logic unused_scanline;
  assign unused_scanline = scanline_on;
`endif
  // counters start saturated so nothing is shown before real sync edges arrive
  always_ff @(posedge clk_sys)
    if (reset) begin
      p1              <= port_t'(8'hC0);
      prev_hs         <= 1'b1;
      prev_vs         <= 1'b1;
      hcnt            <= SAT;
      vcnt            <= SAT;
      vid.vga_r       <= '0;
      vid.vga_g       <= '0;
      vid.vga_b       <= '0;
      vid.vga_hs      <= SYNC_IDLE;
      vid.vga_vs      <= SYNC_IDLE;
      vid.hblank      <= 1'b1;
      vid.vblank      <= 1'b1;
      vid.frame_start <= 1'b0;
    end else begin
      vid.frame_start <= tick && v_nxt == CW'(V_BP) && h_nxt == CW'(H_BP);
      if (tick) begin
        p1         <= port_t'(port_in);
        prev_hs    <= p1.hs_n;
        prev_vs    <= p1.vs_n;
        hcnt       <= h_nxt;
        vcnt       <= v_nxt;
        vid.hblank <= ~act_h;
        vid.vblank <= ~act_v;
        vid.vga_r  <= (act_h && act_v) ? r_x : '0;
        vid.vga_g  <= (act_h && act_v) ? g_x : '0;
        vid.vga_b  <= (act_h && act_v) ? b_x : '0;
        vid.vga_hs <= (SYNC_POS != 0) ? ~p1.hs_n : p1.hs_n;
        vid.vga_vs <= (SYNC_POS != 0) ? ~p1.vs_n : p1.vs_n;
      end
    end
endmodule
